// File: rtl/alu_seq_unit.sv
// alu_seq_unit: EX-stage ALU with ALUOp/funct decode, registered single-cycle
// results, and an iterative unsigned shift-add multiplier / restoring divider.
// Valid/ready handshakes on both sides let the pipeline stall on long ops.
// Optional feature macro: ALU_DIVIDER_EN (DIVU support; when undefined DIVU
// decodes as illegal and no divider logic or DIV state exists).
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             illegal
);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;

`ifdef ALU_DIVIDER_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;       // product high accumulator / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor, latched at accept
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_ill;
    logic             last_iter;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt;
    logic [WIDTH-1:0] mul_lo_nxt;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_quo_nxt;

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt_q == SHW'(WIDTH - 1));

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    // Decode ALUOp/funct and compute the single-cycle result for the current inputs.
    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_ill = 1'b0;
        is_mul = 1'b0;
        is_div = 1'b0;
        case (ALUOp)
            2'b01:   sc_res = a - b;
            2'b10,
            2'b11:   sc_res = a + b;
            default: begin
                case (funct)
                    F_ADD:   sc_res = a + b;
                    F_SUB:   sc_res = a - b;
                    F_AND:   sc_res = a & b;
                    F_OR:    sc_res = a | b;
                    F_SLT:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    F_SLL:   sc_res = b << shamt;
                    F_SRL:   sc_res = b >> shamt;
                    F_MULTU: is_mul = 1'b1;
`ifdef ALU_DIVIDER_EN
                    F_DIVU: begin
                        // Divide by zero finishes at once: all-ones quotient, dividend as remainder.
                        if (b == '0) begin
                            sc_res = '1;
                            sc_hi  = a;
                        end else begin
                            is_div = 1'b1;
                        end
                    end
`endif
                    default: sc_ill = 1'b1;
                endcase
            end
        endcase
    end

    // One shift-add multiply step and one restoring divide step from the working registers.
    always_comb begin
        mul_sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_hi_nxt  = mul_sum[WIDTH:1];
        mul_lo_nxt  = {mul_sum[0], lo_q[WIDTH-1:1]};
        div_shift   = {hi_q, lo_q[WIDTH-1]};
        div_ge      = (div_shift >= {1'b0, opnd_q});
        div_rem_nxt = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
        div_quo_nxt = {lo_q[WIDTH-2:0], div_ge};
    end

    // Next-state and output-register logic for the control FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (is_mul) begin
                        state_d     = S_MUL;
                        cnt_d       = '0;
                        hi_d        = '0;
                        lo_d        = b;
                        opnd_d      = a;
                        out_valid_d = 1'b0;
                    end else if (is_div) begin
`ifdef ALU_DIVIDER_EN
                        state_d     = S_DIV;
`endif
                        cnt_d       = '0;
                        hi_d        = '0;
                        lo_d        = a;
                        opnd_d      = b;
                        out_valid_d = 1'b0;
                    end else begin
                        result_d    = sc_res;
                        result_hi_d = sc_hi;
                        zero_d      = (sc_res == '0);
                        illegal_d   = sc_ill;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                hi_d  = mul_hi_nxt;
                lo_d  = mul_lo_nxt;
                cnt_d = cnt_q + SHW'(1);
                if (last_iter) begin
                    result_d    = mul_lo_nxt;
                    result_hi_d = mul_hi_nxt;
                    zero_d      = (mul_lo_nxt == '0);
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
`ifdef ALU_DIVIDER_EN
            S_DIV: begin
                hi_d  = div_rem_nxt;
                lo_d  = div_quo_nxt;
                cnt_d = cnt_q + SHW'(1);
                if (last_iter) begin
                    result_d    = div_quo_nxt;
                    result_hi_d = div_rem_nxt;
                    zero_d      = (div_quo_nxt == '0);
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any iteration immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Testbench for alu_seq_unit: directed cases, randomized ops against a
// plain-arithmetic reference model, stall/hold, back-to-back and reset abort.
module tb_alu_seq_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    ALUOp = 2'b00;
    logic [5:0]    funct = 6'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [4:0]    shamt = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          zero;
    logic          illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct(funct), .a(a), .b(b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .result_hi(result_hi), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: the arithmetic the ALU is meant to perform, plus its latency.
    task automatic ref_model(input logic [1:0] op, input logic [5:0] f,
                             input logic [31:0] av, input logic [31:0] bv, input logic [4:0] sh,
                             output logic [31:0] r, output logic [31:0] rh,
                             output logic ill, output int lat);
        logic [63:0] prod;
        r = 0; rh = 0; ill = 0; lat = 1;
        if (op == 2'b01) r = av - bv;
        else if (op != 2'b00) r = av + bv;
        else begin
            case (f)
                6'b100000: r = av + bv;
                6'b100010: r = av - bv;
                6'b100100: r = av & bv;
                6'b100101: r = av | bv;
                6'b101010: r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
                6'b000000: r = bv << sh;
                6'b000010: r = bv >> sh;
                6'b011001: begin
                    prod = 64'(av) * 64'(bv);
                    r = prod[31:0]; rh = prod[63:32]; lat = 33;
                end
`ifdef ALU_DIVIDER_EN
                6'b011011: begin
                    if (bv == 0) begin r = 32'hFFFF_FFFF; rh = av; end
                    else begin r = av / bv; rh = av % bv; lat = 33; end
                end
`endif
                default: ill = 1;
            endcase
        end
    endtask

    // Issue one op, measure latency, check outputs, optionally stall, then consume.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] av, input logic [31:0] bv, input logic [4:0] sh,
                         input int hold);
        logic [31:0] er, eh;
        logic        eill;
        int          elat, lat, cnt;
        ref_model(op, f, av, bv, sh, er, eh, eill, elat);
        @(negedge clk);
        cnt = 0;
        while (!in_ready && cnt < 100) begin @(negedge clk); cnt++; end
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        ALUOp = op; funct = f; a = av; b = bv; shamt = sh;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; funct = 6'($urandom); ALUOp = 2'($urandom);
        lat = 1;
        forever begin
            @(negedge clk);
            if (out_valid || lat > 100) break;
            if (lat == 2) check({tag, ".busy_in_ready"}, 64'(in_ready), 64'd0);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".result"}, 64'(result), 64'(er));
        check({tag, ".result_hi"}, 64'(result_hi), 64'(eh));
        check({tag, ".zero"}, 64'(zero), 64'(er == 0));
        check({tag, ".illegal"}, 64'(illegal), 64'(eill));
        $display("op %s ALUOp=%b funct=%b a=%h b=%h sh=%0d -> res=%h hi=%h ill=%0d lat=%0d",
                 tag, op, f, av, bv, sh, result, result_hi, illegal, lat);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, ".hold"}, {31'd0, out_valid, result}, {31'd1, er});
            check({tag, ".hold_hi"}, {30'd0, in_ready, zero, result_hi}, {30'd0, 1'b0, (er == 0), eh});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, ".consumed"}, 64'(out_valid), 64'd0);
    endtask

    logic [5:0] sc_funcs [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010};

    initial begin
        logic [31:0] exp_r [20];
        logic [31:0] exp_h [20];
        logic        exp_i [20];
        logic [31:0] rr, rh, ra, rb;
        logic        ri;
        logic [1:0]  rop;
        logic [5:0]  rf;
        int          rl, cnt;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.result", {result_hi, result}, 64'd0);
        check("rst.zero", 64'(zero), 64'd1);
        check("rst.illegal", 64'(illegal), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'd1);

        // Directed cases
        do_op("add",   2'b00, 6'b100000, 32'd5, 32'd7, 5'd0, 0);
        do_op("beq",   2'b01, 6'b111111, 32'h1234, 32'h1234, 5'd0, 0);
        do_op("lw",    2'b10, 6'b000010, 32'h100, 32'h20, 5'd0, 0);
        do_op("slt",   2'b00, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
        do_op("sll",   2'b00, 6'b000000, 32'd0, 32'd1, 5'd31, 0);
        do_op("srl",   2'b00, 6'b000010, 32'd0, 32'h8000_0000, 5'd31, 0);
        do_op("ill",   2'b00, 6'b111111, 32'd3, 32'd4, 5'd0, 0);
        do_op("multu", 2'b00, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0);
        do_op("divu",  2'b00, 6'b011011, 32'd100, 32'd7, 5'd0, 0);
        do_op("divu0", 2'b00, 6'b011011, 32'd100, 32'd0, 5'd0, 0);
        do_op("hold",  2'b00, 6'b100010, 32'd9, 32'd2, 5'd0, 5);
        do_op("mhold", 2'b00, 6'b011001, 32'd12345, 32'd678, 5'd0, 5);

        // Randomized ops
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom);
            case ($urandom_range(0, 9))
                0, 1:    rf = 6'b011001;
                2:       rf = 6'b011011;
                3:       rf = 6'($urandom);
                default: rf = sc_funcs[$urandom_range(0, 6)];
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom));
            do_op($sformatf("rnd%0d", i), rop, rf, ra, rb, 5'($urandom), $urandom_range(0, 2));
        end

        // Back-to-back single-cycle ops with consumer always ready
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                check("b2b.valid", {62'd0, out_valid, in_ready}, 64'd3);
                check("b2b.result", {31'd0, illegal, result}, {31'd0, exp_i[i-1], exp_r[i-1]});
                check("b2b.hi", 64'(result_hi), 64'(exp_h[i-1]));
                $display("b2b %0d res=%h hi=%h ill=%0d", i - 1, result, result_hi, illegal);
            end
            if (i < 20) begin
                ALUOp = 2'($urandom); funct = sc_funcs[$urandom_range(0, 6)];
                a = $urandom; b = $urandom; shamt = 5'($urandom);
                in_valid = 1'b1;
                ref_model(ALUOp, funct, a, b, shamt, rr, rh, ri, rl);
                exp_r[i] = rr; exp_h[i] = rh; exp_i[i] = ri;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;

        // Reset in the middle of a MULTU
        @(negedge clk);
        cnt = 0;
        while (!in_ready && cnt < 100) begin @(negedge clk); cnt++; end
        ALUOp = 2'b00; funct = 6'b011001; a = 32'd7; b = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rstmid.out_valid", 64'(out_valid), 64'd0);
        check("rstmid.regs", {zero, illegal, result_hi, result}, 66'(2'b10) << 64);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rstmid.aborted", {62'd0, out_valid, in_ready}, 64'd1);
        $display("rstmid out_valid=%0d in_ready=%0d", out_valid, in_ready);
        do_op("after_rst", 2'b00, 6'b100101, 32'hF0, 32'h0F, 5'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
